// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: default widths, the
// reserved "no tag" value, requester slot numbering and a pointer helper.
package cdb_pkg;

    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;

    // Tag value that marks "no destination"; never broadcast on a bus.
    localparam int NO_TAG = 0;

    // Requester slot assignment on the req_* vectors.
    localparam int REQ_ALU0   = 0;
    localparam int REQ_ALU1   = 1;
    localparam int REQ_LOAD   = 2;
    localparam int REQ_BRANCH = 3;

    // Round-robin successor of a slot index, wrapping at num.
    function automatic int rr_next(input int idx, input int num);
        int nxt;
        nxt = idx + 32'sd1;
        if (nxt >= num) begin
            nxt = 32'sd0;
        end else begin
            nxt = idx + 32'sd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Rotating first-set finder: scans mask starting at ptr, wrapping at N, and
// returns the first set bit as a one-hot vector plus its index.
module cdb_rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          found
);
    import cdb_pkg::*;

    logic [PW:0]   sum_s;
    logic [PW-1:0] pos_s;
    logic          take_s;

    // Walk slots ptr, ptr+1, ... (mod N) and latch the first requesting one.
    always_comb begin
        grant  = '0;
        idx    = '0;
        found  = 1'b0;
        sum_s  = '0;
        pos_s  = '0;
        take_s = 1'b0;
        for (int off = 0; off < N; off++) begin
            sum_s = {1'b0, ptr} + (PW+1)'(off);
            if (sum_s >= (PW+1)'(N)) begin
                pos_s = PW'(sum_s - (PW+1)'(N));
            end else begin
                pos_s = PW'(sum_s);
            end
            take_s        = mask[pos_s] & ~found;
            grant[pos_s]  = grant[pos_s] | take_s;
            idx           = take_s ? pos_s : idx;
            found         = found | take_s;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-bus result broadcast arbiter. Each cycle up to two producing units win
// in round-robin order, with units that have waited MAX_WAIT cycles scanned
// first. Winners are broadcast on bus 0 / bus 1 one cycle after acceptance.
// Tag-0 requests are accepted and dropped, flagging a sticky error.
module cdb_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int TAG_W    = cdb_pkg::TAG_W,
    parameter int DATA_W   = cdb_pkg::DATA_W,
    parameter int MAX_WAIT = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_value,
    output logic                      cdb_valid2,
    output logic [TAG_W-1:0]          cdb_tag2,
    output logic [DATA_W-1:0]         cdb_value2,
    output logic                      err_tag0
);
    import cdb_pkg::*;

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = 4;

    logic [PW-1:0]      ptr_r;
    logic [CW-1:0]      wait_r [NUM_REQ];

    logic [NUM_REQ-1:0] elig_s, zero_s, boost_s, norm_s;
    logic [NUM_REQ-1:0] boost1_s, norm1_s;
    logic [NUM_REQ-1:0] b0_grant_s, n0_grant_s, b1_grant_s, n1_grant_s;
    logic [PW-1:0]      b0_idx_s, n0_idx_s, b1_idx_s, n1_idx_s;
    logic               b0_found_s, n0_found_s, b1_found_s, n1_found_s;
    logic [NUM_REQ-1:0] w0_s, w1_s;
    logic [PW-1:0]      w0_idx_s, w1_idx_s, last_idx_s;
    logic               w0_found_s, w1_found_s;
    logic               live_s;
    logic [NUM_REQ-1:0] g0_s, g1_s;
    logic [TAG_W-1:0]   bus0_tag_s, bus1_tag_s;
    logic [DATA_W-1:0]  bus0_val_s, bus1_val_s;

    // Split requests into eligible (real tag), tag-0, boosted and normal sets.
    always_comb begin
        elig_s  = '0;
        zero_s  = '0;
        boost_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_s[i]  = req_valid[i] & (req_tag[i*TAG_W +: TAG_W] != TAG_W'(NO_TAG));
            zero_s[i]  = req_valid[i] & (req_tag[i*TAG_W +: TAG_W] == TAG_W'(NO_TAG));
            boost_s[i] = elig_s[i] & (wait_r[i] == CW'(MAX_WAIT));
        end
        norm_s = elig_s & ~boost_s;
    end

    cdb_rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick_b0 (
        .mask(boost_s), .ptr(ptr_r), .grant(b0_grant_s), .idx(b0_idx_s), .found(b0_found_s)
    );
    cdb_rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick_n0 (
        .mask(norm_s), .ptr(ptr_r), .grant(n0_grant_s), .idx(n0_idx_s), .found(n0_found_s)
    );

    // First winner: boosted requesters take precedence over normal ones.
    always_comb begin
        if (b0_found_s) begin
            w0_s     = b0_grant_s;
            w0_idx_s = b0_idx_s;
        end else begin
            w0_s     = n0_grant_s;
            w0_idx_s = n0_idx_s;
        end
        w0_found_s = b0_found_s | n0_found_s;
    end

    // Remove the first winner before looking for the second.
    always_comb begin
        boost1_s = boost_s & ~w0_s;
        norm1_s  = norm_s & ~w0_s;
    end

    cdb_rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick_b1 (
        .mask(boost1_s), .ptr(ptr_r), .grant(b1_grant_s), .idx(b1_idx_s), .found(b1_found_s)
    );
    cdb_rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick_n1 (
        .mask(norm1_s), .ptr(ptr_r), .grant(n1_grant_s), .idx(n1_idx_s), .found(n1_found_s)
    );

    // Second winner, same boosted-first rule on the reduced masks.
    always_comb begin
        if (b1_found_s) begin
            w1_s     = b1_grant_s;
            w1_idx_s = b1_idx_s;
        end else begin
            w1_s     = n1_grant_s;
            w1_idx_s = n1_idx_s;
        end
        w1_found_s = b1_found_s | n1_found_s;
    end

    // Grants are suppressed during reset and flush; the pointer follows the
    // last winner in priority order.
    always_comb begin
        live_s = ~rst & ~flush;
        if (live_s) begin
            g0_s      = w0_s;
            g1_s      = w1_s;
            req_ready = w0_s | w1_s | zero_s;
        end else begin
            g0_s      = '0;
            g1_s      = '0;
            req_ready = '0;
        end
        if (w1_found_s) begin
            last_idx_s = w1_idx_s;
        end else begin
            last_idx_s = w0_idx_s;
        end
    end

    // One-hot AND-OR select of the winning tag/value for each bus.
    always_comb begin
        bus0_tag_s = '0;
        bus0_val_s = '0;
        bus1_tag_s = '0;
        bus1_val_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus0_tag_s = bus0_tag_s | (req_tag[i*TAG_W +: TAG_W]    & {TAG_W{g0_s[i]}});
            bus0_val_s = bus0_val_s | (req_value[i*DATA_W +: DATA_W] & {DATA_W{g0_s[i]}});
            bus1_tag_s = bus1_tag_s | (req_tag[i*TAG_W +: TAG_W]    & {TAG_W{g1_s[i]}});
            bus1_val_s = bus1_val_s | (req_value[i*DATA_W +: DATA_W] & {DATA_W{g1_s[i]}});
        end
    end

    // Broadcast registers, rr pointer, wait counters and sticky tag-0 flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_value  <= '0;
            cdb_valid2 <= 1'b0;
            cdb_tag2   <= '0;
            cdb_value2 <= '0;
            err_tag0   <= 1'b0;
            ptr_r      <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_r[i] <= '0;
            end
        end else begin
            cdb_valid  <= |g0_s;
            cdb_tag    <= bus0_tag_s;
            cdb_value  <= bus0_val_s;
            cdb_valid2 <= |g1_s;
            cdb_tag2   <= bus1_tag_s;
            cdb_value2 <= bus1_val_s;
            if (!flush && w0_found_s) begin
                ptr_r <= PW'(rr_next(int'(last_idx_s), NUM_REQ));
            end else begin
                ptr_r <= ptr_r;
            end
            if (!flush && (|zero_s)) begin
                err_tag0 <= 1'b1;
            end else begin
                err_tag0 <= err_tag0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush || !elig_s[i] || g0_s[i] || g1_s[i]) begin
                    wait_r[i] <= '0;
                end else if (wait_r[i] < CW'(MAX_WAIT)) begin
                    wait_r[i] <= wait_r[i] + 4'd1;
                end else begin
                    wait_r[i] <= wait_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based priority model of the arbiter.
module tb_cdb_arbiter;

    localparam int N  = 6;
    localparam int TW = 5;
    localparam int DW = 32;
    localparam int MW = 2;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic [N-1:0]    req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_value;
    logic [N-1:0]    req_ready;
    logic            cdb_valid, cdb_valid2, err_tag0;
    logic [TW-1:0]   cdb_tag, cdb_tag2;
    logic [DW-1:0]   cdb_value, cdb_value2;

    int checks = 0;
    int failures = 0;

    // stimulus for the current cycle
    bit          s_valid [N];
    int          s_tag   [N];
    logic [31:0] s_val   [N];
    bit          s_flush, s_rst;

    // reference model state and expected broadcast
    int            m_ptr;
    int            m_wait [N];
    bit            m_err;
    bit            e_v0, e_v1;
    logic [TW-1:0] e_t0, e_t1;
    logic [DW-1:0] e_d0, e_d1;
    logic [N-1:0]  last_rdy;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
        .req_ready(req_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_valid2(cdb_valid2), .cdb_tag2(cdb_tag2), .cdb_value2(cdb_value2),
        .err_tag0(err_tag0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            s_valid[i] = 1'b0;
            s_tag[i]   = 0;
            s_val[i]   = 32'h0;
        end
    endtask

    task automatic set_req(input int i, input int tag, input logic [31:0] val);
        s_valid[i] = 1'b1;
        s_tag[i]   = tag;
        s_val[i]   = val;
    endtask

    // Priority list: boosted units in rotated order, then the other eligible ones.
    task automatic model_pick(output int w0, output int w1);
        int order[$];
        int i;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (s_valid[i] && s_tag[i] != 0 && ((m_wait[i] == MW) == (pass == 0)))
                    order.push_back(i);
            end
        end
        w0 = (order.size() > 0) ? order[0] : -1;
        w1 = (order.size() > 1) ? order[1] : -1;
    endtask

    // Apply one cycle of stimulus, check grants mid-cycle and buses after the edge.
    task automatic cycle();
        int w0, w1, last;
        logic [N-1:0] exp_rdy;
        rst   = s_rst;
        flush = s_flush;
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = s_valid[i];
            req_tag[i*TW +: TW]     = TW'(s_tag[i]);
            req_value[i*DW +: DW]   = s_val[i];
        end
        @(negedge clk);
        model_pick(w0, w1);
        exp_rdy = '0;
        if (!s_rst && !s_flush) begin
            if (w0 >= 0) exp_rdy[w0] = 1'b1;
            if (w1 >= 0) exp_rdy[w1] = 1'b1;
            for (int i = 0; i < N; i++)
                if (s_valid[i] && s_tag[i] == 0) exp_rdy[i] = 1'b1;
        end
        last_rdy = req_ready;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));

        e_v0 = 1'b0; e_t0 = '0; e_d0 = '0;
        e_v1 = 1'b0; e_t1 = '0; e_d1 = '0;
        if (s_rst) begin
            m_ptr = 0;
            m_err = 1'b0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else if (s_flush) begin
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else begin
            if (w0 >= 0) begin e_v0 = 1'b1; e_t0 = TW'(s_tag[w0]); e_d0 = s_val[w0]; end
            if (w1 >= 0) begin e_v1 = 1'b1; e_t1 = TW'(s_tag[w1]); e_d1 = s_val[w1]; end
            last = (w1 >= 0) ? w1 : w0;
            if (last >= 0) m_ptr = (last + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (s_valid[i] && s_tag[i] == 0) m_err = 1'b1;
                if (!(s_valid[i] && s_tag[i] != 0) || i == w0 || i == w1) m_wait[i] = 0;
                else if (m_wait[i] < MW) m_wait[i] = m_wait[i] + 1;
            end
        end
        @(posedge clk);
        #1;
        check("bus0", 64'({cdb_valid, cdb_tag, cdb_value}), 64'({e_v0, e_t0, e_d0}));
        check("bus1", 64'({cdb_valid2, cdb_tag2, cdb_value2}), 64'({e_v1, e_t1, e_d1}));
        check("err_tag0", 64'(err_tag0), 64'(m_err));
    endtask

    initial begin
        int t0_exp [4];
        int t1_exp [4];
        t0_exp = '{1, 3, 1, 3};
        t1_exp = '{2, 4, 2, 4};
        m_ptr = 0;
        m_err = 1'b0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        clear_reqs();
        s_flush = 1'b0;
        s_rst   = 1'b1;

        // reset for two cycles, then idle
        cycle();
        cycle();
        s_rst = 1'b0;
        cycle();
        check("idle_ready", 64'(last_rdy), 64'd0);
        check("idle_valid", 64'({cdb_valid, cdb_valid2, cdb_tag, cdb_tag2}), 64'd0);

        // single request on unit 0
        set_req(0, 3, 32'h11);
        cycle();
        check("single_ready", 64'(last_rdy), 64'b000001);
        check("single_bus0", 64'({cdb_valid, cdb_tag, cdb_value}), 64'({1'b1, 5'd3, 32'h11}));
        check("single_bus1", 64'(cdb_valid2), 64'd0);
        clear_reqs();

        // full contention rotation on units 0..3 from pointer 0
        s_rst = 1'b1;
        cycle();
        s_rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, i + 1, 32'hA0 + 32'(i));
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("rot_tag0", 64'(cdb_tag), 64'(t0_exp[c]));
            check("rot_tag1", 64'(cdb_tag2), 64'(t1_exp[c]));
        end
        clear_reqs();

        // starvation boost: unit 5 loses twice, then leads bus 0 ahead of unit 4
        s_rst = 1'b1;
        cycle();
        s_rst = 1'b0;
        set_req(0, 1, 32'h100); set_req(1, 2, 32'h101); set_req(5, 6, 32'h105);
        cycle();
        clear_reqs();
        set_req(2, 3, 32'h102); set_req(3, 4, 32'h103); set_req(5, 6, 32'h105);
        cycle();
        clear_reqs();
        set_req(4, 5, 32'h104); set_req(5, 6, 32'h105);
        cycle();
        check("boost_bus0", 64'(cdb_tag), 64'd6);
        check("boost_bus1", 64'(cdb_tag2), 64'd5);
        clear_reqs();

        // tag-0 request: accepted, dropped, sticky error
        set_req(2, 0, 32'h55);
        cycle();
        check("tag0_ready", 64'(last_rdy), 64'b000100);
        check("tag0_nobus", 64'({cdb_valid, cdb_valid2}), 64'd0);
        check("tag0_err", 64'(err_tag0), 64'd1);
        clear_reqs();
        cycle();
        check("tag0_sticky", 64'(err_tag0), 64'd1);

        // flush keeps pointer (5): afterwards units 5 then 3 win
        set_req(3, 4, 32'h203); set_req(4, 5, 32'h204); set_req(5, 6, 32'h205);
        s_flush = 1'b1;
        cycle();
        check("flush_ready", 64'(last_rdy), 64'd0);
        check("flush_idle", 64'({cdb_valid, cdb_valid2}), 64'd0);
        s_flush = 1'b0;
        cycle();
        check("flush_ptr0", 64'(cdb_tag), 64'd6);
        check("flush_ptr1", 64'(cdb_tag2), 64'd4);

        // mid-op reset returns pointer to 0: afterwards units 3 then 4 win
        s_rst = 1'b1;
        cycle();
        check("rst_ready", 64'(last_rdy), 64'd0);
        check("rst_idle", 64'({cdb_valid, cdb_valid2, err_tag0}), 64'd0);
        s_rst = 1'b0;
        cycle();
        check("rst_ptr0", 64'(cdb_tag), 64'd4);
        check("rst_ptr1", 64'(cdb_tag2), 64'd5);
        clear_reqs();

        // random traffic; unaccepted requests are held, as producers do
        for (int c = 0; c < 600; c++) begin
            s_rst   = ($urandom_range(0, 59) == 0);
            s_flush = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < N; i++) begin
                if (!(s_valid[i] && !last_rdy[i] && $urandom_range(0, 7) != 0)) begin
                    s_valid[i] = ($urandom_range(0, 3) != 0);
                    s_tag[i]   = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 31));
                    s_val[i]   = $urandom;
                end
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the two result-broadcast buses (bus 0 / bus 1) between NUM_REQ producing units: ALU pipe 0, ALU pipe 1, load unit and branch unit.
- The buses feed the reservation station wakeup ports (alu_res_tag/alu_res and alu_res_tag2/alu_res2) and the ROB write ports.
- Grants up to two requesters per cycle using round-robin order with a starvation boost.
- Broadcast outputs are registered.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, 5, ROB/RS tag width; tag 0 is reserved as "no tag".
- DATA_W, 32, result width.
- MAX_WAIT, 7, wait cycles after which a pending requester is boosted (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  pipeline flush; discard this cycle's arbitration
- req_valid  in  NUM_REQ  request pending per unit; held until accepted
- req_tag  in  NUM_REQ*TAG_W  destination tag per unit, requester i in slice i
- req_value  in  NUM_REQ*DATA_W  result value per unit
- req_ready  out  NUM_REQ  combinational grant; request accepted when req_valid&req_ready
- cdb_valid  out  1  bus 0 carries a result
- cdb_tag  out  TAG_W  bus 0 tag (0 when idle)
- cdb_value  out  DATA_W  bus 0 value (0 when idle)
- cdb_valid2  out  1  bus 1 carries a result
- cdb_tag2  out  TAG_W  bus 1 tag (0 when idle)
- cdb_value2  out  DATA_W  bus 1 value (0 when idle)
- err_tag0  out  1  sticky: a request arrived with tag 0

Behaviour:
- Reset (rst=1 at posedge): all cdb_* = 0, err_tag0 = 0, rr pointer = 0, all wait counters = 0.
- req_ready is 0 while rst=1 or flush=1.
- Eligible set E = {i : req_valid[i] and req_tag[i] != 0}.
- Requests with tag 0:
  - Accepted (req_ready=1) in the same cycle and dropped, never broadcast.
  - Set err_tag0.
  - Do not consume a bus slot.
- Priority order, evaluated every cycle, combinationally:
  - Boosted requesters first: wait counter == MAX_WAIT, scanned ptr, ptr+1, … mod NUM_REQ.
  - Then remaining requesters in E, same rotated scan.
  - First two in that order win.
- Winner W0 drives bus 0 and W1 drives bus 1, registered at the next posedge (latency 1 cycle from acceptance to broadcast).
- With one winner: bus 1 idle (valid/tag/value = 0).
- With none: both buses idle.
- Outputs are rewritten every cycle; a bus never holds a stale value for more than one cycle.
- Pointer update:
  - Pointer = (index of last winner + 1) mod NUM_REQ.
  - Unchanged when there is no winner.
  - Wraps NUM_REQ-1 → 0.
- Wait counters, per requester:
  - +1 when in E and not granted; saturates at MAX_WAIT.
  - Cleared when granted or when req_valid=0.
- flush=1:
  - No grants; next-cycle buses idle.
  - Wait counters cleared; pointer unchanged; err_tag0 unchanged.
  - Requesters are expected to drop their requests on flush.
- Duplicate tags in one cycle are not checked; both are broadcast, bus 0 carrying the lower-priority-order winner.
- Reset mid-operation: pending grants are lost and buses are idle the following cycle.
- Guaranteed bound: with ≥2 winners per cycle, any continuously valid requester is granted within MAX_WAIT+ceil(NUM_REQ/2) cycles.

Decomposition:
- Shared package cdb_pkg:
  - TAG_W, DATA_W, NO_TAG = 0.
  - Requester index constants: REQ_ALU0 = 0, REQ_ALU1 = 1, REQ_LOAD = 2, REQ_BRANCH = 3.
- Sub-module cdb_rr_picker: given a request mask and start pointer, returns a one-hot first-set in rotated order.
  - Instantiated for the boosted mask and the normal mask.
  - Second winner = picker on the mask with W0 removed.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all req_valid=0 → cdb_valid=cdb_valid2=0, tags/values 0, req_ready=0000.
- Single request: req_valid=0001, tag 3, value 0x11 → req_ready=0001 same cycle; next cycle cdb_valid=1, cdb_tag=3, cdb_value=0x11; bus 1 idle; pointer becomes 1.
- Full contention rotation: all 4 valid, tags 1..4, held for 4 cycles → grant pairs (0,1), (2,3), (0,1), (2,3); bus 0 tags 1,3,1,3; bus 1 tags 2,4,2,4.
- Starvation boost: MAX_WAIT=2; units 0,1 always valid; unit 3 valid with the pointer forced so it loses → unit 3 is granted no later than the cycle after its counter reaches 2, and appears on bus 0.
- Tag-0 request: req_valid=0100 with req_tag[2]=0 → req_ready=0100, no broadcast next cycle, err_tag0=1 and it stays 1 until rst.
- Flush and mid-op reset: 3 valid requests with flush=1 → req_ready=000, buses idle next cycle, pointer unchanged; repeat with rst=1 instead → pointer = 0, buses idle.
